sl_receiver: RTL and testbench

SL_RECEIVER -- requirements
Module: sl_receiver

---
 rtl/sl_pkg.sv | 15 +
 rtl/sl_sync.sv | 26 ++
 rtl/sl_receiver.sv | 118 +++++++++++
 tb/tb_sl_receiver.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sl_pkg.sv
// sl_pkg: shared types and constants for the SL receiver and transmitter
// Holds the FSM state enum, the config field positions, the status bit indices and the reset config value.
package sl_pkg;
   typedef enum logic [2:0] {IDLE, BIT0, BIT1, GAP, STOP} sl_state_t;
   localparam int CFG_LEN_MSB = 5;
   localparam int CFG_PAR = 6;
   localparam int CFG_CLR = 7;
   localparam int ST_LEN = 0;
   localparam int ST_PAR = 1;
   localparam int ST_TO = 2;
   localparam int ST_PROTO = 3;
   localparam logic [9:0] CFG_DEFAULT = 10'h020;
   localparam logic [5:0] MAX_LEN = 6'd32;
   localparam logic [5:0] CNT_SAT = 6'd33;
endpackage

// File: rtl/sl_sync.sv
// sl_sync: multi-flop synchronizer for the two idle-high SL lines
// Ports: clk, rst (sync, active high) | raw0, raw1 async lines | sync0, sync1 synchronized levels.
module sl_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic raw0,
   input  logic raw1,
   output logic sync0,
   output logic sync1
);
   logic [STAGES-1:0] r0, r1;
   // Flops reset to 1 so the lines look idle coming out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r0 <= '1;
         r1 <= '1;
      end else begin
         r0 <= STAGES'({r0, raw0});
         r1 <= STAGES'({r1, raw1});
      end
   end
   assign sync0 = r0[STAGES-1];
   assign sync1 = r1[STAGES-1];
endmodule

// File: rtl/sl_receiver.sv
// sl_receiver: two-wire SL frame receiver with length/parity/timeout/protocol checking
// Ports: clk, rst (sync, active high) | SL0, SL1 async idle-high lines |
//        wr_config_w/wr_config_en config write | r_config_w config readback |
//        data_out/data_valid received word and pulse | status sticky errors | receive_in_process.
module sl_receiver
   import sl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SL0,
   input  logic        SL1,
   input  logic [9:0]  wr_config_w,
   input  logic        wr_config_en,
   output logic [9:0]  r_config_w,
   output logic [31:0] data_out,
   output logic        data_valid,
   output logic [3:0]  status,
   output logic        receive_in_process
);
   localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES - 1);
   sl_state_t state, nxt;
   logic s0, s1, p0, p1, chg, tmo, in_bit, shift, proto, start, frame_end, len_ok, par_ok, good;
   logic cfg_par, fr_par, fr_bad;
   logic [5:0] cfg_len, fr_len, cnt;
   logic [31:0] sh, tcnt;
   logic [3:0] set;

   sl_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .raw0 (SL0),
      .raw1 (SL1),
      .sync0(s0),
      .sync1(s1)
   );

   assign chg = (s0 != p0) || (s1 != p1);
   assign in_bit = (state == BIT0) || (state == BIT1);
   assign receive_in_process = (state != IDLE);
   assign r_config_w = {3'b000, cfg_par, cfg_len};

   always_comb begin
      nxt = state;
      // Leaving IDLE needs the previous sample idle, so a line still held low after an abort cannot restart a frame.
      case (state)
         IDLE: if (p0 && p1) nxt = (!s0 && !s1) ? STOP : !s0 ? BIT0 : !s1 ? BIT1 : IDLE;
         BIT0: nxt = !s1 ? STOP : s0 ? GAP : BIT0;
         BIT1: nxt = !s0 ? STOP : s1 ? GAP : BIT1;
         GAP:  nxt = (!s0 && !s1) ? STOP : !s0 ? BIT0 : !s1 ? BIT1 : GAP;
         STOP: nxt = (s0 && s1) ? IDLE : STOP;
         default: nxt = IDLE;
      endcase
      tmo = (state != IDLE) && !chg && (tcnt == TO_LIM);
      if (tmo) nxt = IDLE;
      shift = in_bit && (nxt == GAP);
      proto = in_bit && (nxt == STOP);
      start = (state == IDLE) && (nxt != IDLE);
      frame_end = (state == STOP) && (nxt == IDLE);
      len_ok = (cnt == fr_len) && (fr_len != 6'd0) && (fr_len <= MAX_LEN);
      par_ok = !fr_par || (^sh);
      // A frame that already saw a protocol error is dropped without further checks.
      good = frame_end && !fr_bad && len_ok && par_ok;
      set = '0;
      set[ST_LEN] = frame_end && !fr_bad && !len_ok;
      set[ST_PAR] = frame_end && !fr_bad && len_ok && !par_ok;
      set[ST_TO] = tmo;
      set[ST_PROTO] = proto;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         p0 <= 1'b1;
         p1 <= 1'b1;
         tcnt <= '0;
         cnt <= '0;
         sh <= '0;
         cfg_len <= CFG_DEFAULT[CFG_LEN_MSB:0];
         cfg_par <= CFG_DEFAULT[CFG_PAR];
         fr_len <= '0;
         fr_par <= 1'b0;
         fr_bad <= 1'b0;
         data_out <= '0;
         data_valid <= 1'b0;
         status <= '0;
      end else begin
         state <= nxt;
         p0 <= s0;
         p1 <= s1;
         tcnt <= (chg || state == IDLE) ? '0 : tcnt + 32'd1;
         if (wr_config_en) begin
            cfg_len <= wr_config_w[CFG_LEN_MSB:0];
            cfg_par <= wr_config_w[CFG_PAR];
         end
         // Frame geometry is frozen at IDLE exit so mid-frame config writes apply to the next frame.
         if (start) begin
            fr_len <= cfg_len;
            fr_par <= cfg_par;
            fr_bad <= 1'b0;
            cnt <= '0;
            sh <= '0;
         end else begin
            if (shift) begin
               sh <= {sh[30:0], state == BIT1};
               cnt <= (cnt == CNT_SAT) ? cnt : cnt + 6'd1;
            end
            if (proto) fr_bad <= 1'b1;
         end
         data_valid <= good;
         if (good) data_out <= sh;
         // Set wins over a same-cycle clear.
         status <= ((wr_config_en && wr_config_w[CFG_CLR]) ? 4'd0 : status) | set;
      end
   end
endmodule

// File: tb/tb_sl_receiver.sv
// tb_sl_receiver: directed self-checking bench for sl_receiver
module tb_sl_receiver;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sl0 = 1'b1;
   logic sl1 = 1'b1;
   logic wr_config_en = 1'b0;
   logic [9:0] wr_config_w = '0;
   logic [9:0] r_config_w;
   logic [31:0] data_out;
   logic data_valid;
   logic [3:0] status;
   logic receive_in_process;
   int checks = 0;
   int errors = 0;
   int dv_cnt = 0;
   int d0;

   sl_receiver #(.TIMEOUT_CYCLES(1000), .SYNC_STAGES(2)) dut (
      .clk               (clk),
      .rst               (rst),
      .SL0               (sl0),
      .SL1               (sl1),
      .wr_config_w       (wr_config_w),
      .wr_config_en      (wr_config_en),
      .r_config_w        (r_config_w),
      .data_out          (data_out),
      .data_valid        (data_valid),
      .status            (status),
      .receive_in_process(receive_in_process)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (data_valid) dv_cnt <= dv_cnt + 1;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      if (b) sl1 = 1'b0;
      else sl0 = 1'b0;
      cyc(3);
      sl0 = 1'b1;
      sl1 = 1'b1;
      cyc(3);
   endtask

   task automatic send_word(input int n, input logic [31:0] w);
      for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic send_stop();
      sl0 = 1'b0;
      sl1 = 1'b0;
      cyc(3);
      sl0 = 1'b1;
      sl1 = 1'b1;
      cyc(8);
   endtask

   task automatic cfg(input logic [9:0] w);
      wr_config_w = w;
      wr_config_en = 1'b1;
      cyc(1);
      wr_config_en = 1'b0;
      cyc(1);
   endtask

   initial begin
      cyc(2);
      rst = 1'b0;
      cyc(1);
      chk("rst_data_out", data_out, 32'h0);
      chk("rst_data_valid", data_valid, 32'h0);
      chk("rst_status", status, 32'h0);
      chk("rst_rip", receive_in_process, 32'h0);
      chk("rst_config", r_config_w, 32'h020);

      cfg(10'h385);
      chk("cfg_readback_reserved", r_config_w, 32'h005);

      d0 = dv_cnt;
      send_bit(1'b1);
      send_bit(1'b0);
      chk("rip_mid_frame", receive_in_process, 32'h1);
      cfg(10'h008);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      sl0 = 1'b0;
      sl1 = 1'b0;
      cyc(3);
      sl0 = 1'b1;
      sl1 = 1'b1;
      cyc(2);
      chk("latency_early", data_valid, 32'h0);
      cyc(1);
      chk("latency_pulse", data_valid, 32'h1);
      cyc(1);
      chk("pulse_one_cycle", data_valid, 32'h0);
      cyc(4);
      chk("n5_data", data_out, 32'h16);
      chk("n5_pulses", 32'(dv_cnt - d0), 32'h1);
      chk("n5_status", status, 32'h0);
      chk("n5_rip_end", receive_in_process, 32'h0);
      chk("midframe_cfg_readback", r_config_w, 32'h008);

      send_word(8, 32'hA5);
      send_stop();
      chk("n8_next_frame_data", data_out, 32'hA5);

      cfg(10'h060);
      d0 = dv_cnt;
      send_word(32, 32'h1);
      send_stop();
      chk("par_odd_data", data_out, 32'h1);
      chk("par_odd_pulse", 32'(dv_cnt - d0), 32'h1);
      chk("par_odd_status", status, 32'h0);
      d0 = dv_cnt;
      send_word(32, 32'h3);
      send_stop();
      chk("par_even_status", status, 32'h2);
      chk("par_even_data_kept", data_out, 32'h1);
      chk("par_even_no_pulse", 32'(dv_cnt - d0), 32'h0);

      cfg(10'h088);
      chk("clear_status", status, 32'h0);
      chk("cfg_n8", r_config_w, 32'h008);
      d0 = dv_cnt;
      send_word(7, 32'h55);
      send_stop();
      chk("short_len_status", status, 32'h1);
      chk("short_data_kept", data_out, 32'h1);
      chk("short_no_pulse", 32'(dv_cnt - d0), 32'h0);

      cfg(10'h085);
      chk("clear_before_timeout", status, 32'h0);
      d0 = dv_cnt;
      sl0 = 1'b0;
      cyc(500);
      chk("timeout_pending_rip", receive_in_process, 32'h1);
      chk("timeout_pending_status", status, 32'h0);
      cyc(510);
      chk("timeout_status", status, 32'h4);
      chk("timeout_rip", receive_in_process, 32'h0);
      sl0 = 1'b1;
      cyc(5);
      chk("timeout_release_idle", receive_in_process, 32'h0);
      chk("timeout_no_pulse", 32'(dv_cnt - d0), 32'h0);

      cfg(10'h085);
      d0 = dv_cnt;
      sl0 = 1'b0;
      cyc(3);
      sl1 = 1'b0;
      cyc(3);
      sl0 = 1'b1;
      sl1 = 1'b1;
      cyc(8);
      chk("proto_status_bit", 32'(status[3]), 32'h1);
      chk("proto_no_pulse", 32'(dv_cnt - d0), 32'h0);
      cfg(10'h085);
      chk("proto_clear", status, 32'h0);
      chk("proto_cfg", r_config_w, 32'h005);

      send_bit(1'b1);
      send_bit(1'b0);
      sl0 = 1'b0;
      cyc(1);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      sl0 = 1'b1;
      cyc(5);
      chk("midrst_status", status, 32'h0);
      chk("midrst_rip", receive_in_process, 32'h0);
      chk("midrst_data", data_out, 32'h0);
      chk("midrst_cfg", r_config_w, 32'h020);
      cfg(10'h005);
      d0 = dv_cnt;
      send_word(5, 32'h9);
      send_stop();
      chk("post_rst_data", data_out, 32'h9);
      chk("post_rst_status", status, 32'h0);
      chk("post_rst_pulse", 32'(dv_cnt - d0), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
